// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write store buffer between the CPU data port and data memory.
// Stores wait in a circular FIFO and drain to memory one per accepted cycle.
// Loads are served from the youngest buffered store to the same word, otherwise
// from the memory's asynchronous read port.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Entry storage and FIFO bookkeeping.
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic enq;
  logic deq;
  logic full;

  // Load type carries no extra meaning here; loads are answered combinationally regardless.
  logic unused_cpu_re;
  assign unused_cpu_re = cpu_re;

  assign full = (count_q == FULL);

  // A store is refused while the buffer is full, even if the head retires this
  // same edge; the held store goes in on the following cycle.
  assign enq = cpu_we & ~reset & ~full;
  assign deq = mem_we & mem_ready & ~reset;

  assign cpu_stall = cpu_we & ~reset & full;
  assign mem_we    = (count_q != '0);
  assign mem_waddr = addr_q[rd_ptr_q];
  assign mem_wdata = data_q[rd_ptr_q];
  assign mem_raddr = cpu_addr;
  assign drained   = (count_q == '0);

  // Next-state pointers and occupancy; enqueue and dequeue together leave count unchanged.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers with synchronous reset; reset drops all pending entries.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write on enqueue; the byte offset is kept and passed through to memory.
  always_ff @(posedge clk) begin
    // NOTE: entry storage is not reset; occupancy decides which entries are meaningful.
    if (enq) begin
      addr_q[wr_ptr_q] <= cpu_addr;
      data_q[wr_ptr_q] <= cpu_wdata;
    end
  end

  // Load forwarding: scan oldest to youngest so the youngest word match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    cpu_rdata = mem_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx][AW-1:2] == cpu_addr[AW-1:2])) begin
        cpu_rdata = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          drained;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .drained   (drained)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];                    // pending stores, oldest first
  ent_t        wlog[$];                 // writes memory has accepted, in order
  logic [31:0] mem_arr [logic [29:0]];  // word-indexed memory contents
  int          errors   = 0;
  int          checks   = 0;
  bit          model_on = 1'b0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem_arr.exists(a[31:2])) return mem_arr[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  // Reference model: a store queue plus a memory, advanced at every posedge.
  always @(posedge clk) begin
    ent_t e;
    bit   was_full;
    if (reset) begin
      q.delete();
    end else begin
      was_full = (q.size() == DEPTH);
      if (q.size() != 0 && mem_ready) begin
        mem_arr[q[0].a[31:2]] = q[0].d;
        wlog.push_back(q[0]);
        q.delete(0);
      end
      if (cpu_we && !was_full) begin
        e.a = cpu_addr;
        e.d = cpu_wdata;
        q.push_back(e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare every observable output with what the model says for the current cycle.
  task automatic compare();
    logic [31:0] exp_rdata;
    exp_rdata = rd_mem(cpu_addr);
    foreach (q[i]) if (q[i].a[31:2] == cpu_addr[31:2]) exp_rdata = q[i].d;
    check("mem_we", 32'(mem_we), 32'(q.size() != 0));
    check("drained", 32'(drained), 32'(q.size() == 0));
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_we && !reset && q.size() == DEPTH));
    check("cpu_rdata", cpu_rdata, exp_rdata);
    check("mem_raddr", mem_raddr, cpu_addr);
    if (q.size() != 0) begin
      check("mem_waddr", mem_waddr, q[0].a);
      check("mem_wdata", mem_wdata, q[0].d);
    end
  endtask

  // One clock cycle: drive after the falling edge, compare before the rising edge.
  task automatic cycle(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic rst);
    @(negedge clk);
    reset     = rst;
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = a;
    cpu_wdata = d;
    mem_ready = rdy;
    mem_rdata = rd_mem(a);
    #2;
    if (model_on) compare();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!drained && n < 40) begin
      cycle(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0);
      n++;
    end
    check("drain_timeout", 32'(drained), 32'd1);
  endtask

  initial begin
    int          base;
    logic        h_we;
    logic [31:0] h_a;
    logic [31:0] h_d;
    int          op;

    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

    // Reset with a store request present: nothing is enqueued.
    cycle(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b1);
    model_on = 1'b1;
    cycle(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 1'b0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_drained", 32'(drained), 32'd1);
    check("rst_stall", 32'(cpu_stall), 32'd0);

    // Single store becomes visible to memory one cycle later.
    cycle(1'b1, 1'b0, 32'h0000_0054, 32'h0000_0011, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0);
    check("st_mem_we", 32'(mem_we), 32'd1);
    check("st_waddr", mem_waddr, 32'h0000_0054);
    check("st_wdata", mem_wdata, 32'h0000_0011);
    cycle(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0);
    check("st_drained", 32'(drained), 32'd1);

    // Fill with memory blocked; fifth store stalls and is held until accepted.
    base = wlog.size();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'(i * 4), 32'h300 + 32'(i), 1'b0, 1'b0);
      check("fill_stall", 32'(cpu_stall), 32'(i == 4));
    end
    cycle(1'b1, 1'b0, 32'h10, 32'h304, 1'b1, 1'b0);
    check("full_retire_stall", 32'(cpu_stall), 32'd1);
    cycle(1'b1, 1'b0, 32'h10, 32'h304, 1'b1, 1'b0);
    check("held_accept", 32'(cpu_stall), 32'd0);
    drain();
    check("order_count", 32'(wlog.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < wlog.size(); i++) begin
      check("order_addr", wlog[base + i].a, 32'(i * 4));
      check("order_data", wlog[base + i].d, 32'h300 + 32'(i));
    end

    // Forwarding: youngest of two stores to the same word; miss goes to memory.
    cycle(1'b1, 1'b0, 32'h20, 32'h7, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h20, 32'hB, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0);
    check("fwd_young", cpu_rdata, 32'hB);
    cycle(1'b0, 1'b1, 32'h24, 32'h0, 1'b0, 1'b0);
    check("fwd_miss", cpu_rdata, 32'h0000_0024 ^ 32'hA5A5_0000);
    drain();
    check("mem_20", rd_mem(32'h20), 32'hB);

    // Three rounds of full buffer with memory ready: exactly one stall cycle each.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++)
        cycle(1'b1, 1'b0, 32'h80 + 32'(i * 4), 32'(r * 16 + i), 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 32'hC0, 32'h900 + 32'(r), 1'b1, 1'b0);
      check("wrap_stall", 32'(cpu_stall), 32'd1);
      cycle(1'b1, 1'b0, 32'hC0, 32'h900 + 32'(r), 1'b1, 1'b0);
      check("wrap_accept", 32'(cpu_stall), 32'd0);
      drain();
    end
    check("wrap_mem", rd_mem(32'h8C), 32'd35);

    // Reset with three pending entries: they never reach memory.
    base = wlog.size();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h55 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_drained", 32'(drained), 32'd1);
    check("mid_rst_nowrite", 32'(wlog.size() - base), 32'd0);

    // Randomized traffic; a stalled store is re-presented unchanged, as the CPU would.
    h_we = 1'b0; h_a = '0; h_d = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!(h_we && cpu_stall)) begin
        op  = int'($urandom_range(0, 2));
        h_we = (op == 0);
        h_a  = {26'd0, 3'($urandom_range(0, 7)), 1'b0, 2'($urandom)};
        h_d  = $urandom;
      end
      cycle(h_we, op == 1, h_a, h_d, $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
